keypad_scanner: RTL
===================

# keypad_scanner

Matrix-keypad front end for the 4x4 key panel. It drives the row lines, samples the column lines, debounces every key, and produces the `key_press` level bus and the `key_edge` one-cycle pulse bus that the game and configuration controllers consume. It sits between the board keypad pins and all controllers that react to key events, such as start, player select, and judge keys.

## Interface
Parameters:
- `SCAN_DIV`, default 100_000: clocks per row slot (1 ms at 100 MHz). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 10: consecutive full frames a key must disagree with its debounced state before that state flips. Must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, **active-low**.
- `row` out 4: row drive, active-low, exactly one bit low at a time.
- `col` in 4: column sense, active-low (pulled up), asynchronous.
- `key_press` out 16: debounced key levels, index = 4*row + col.
- `key_edge` out 16: one-`clk` pulse per debounced press.

## Operation
- **Input sync:** `col` passes through a 2-flop synchronizer, then is inverted internally (1 = closed).
- **Scan FSM:** states `DRIVE` → `SAMPLE` → `DRIVE`.
  - `DRIVE` holds row r for SCAN_DIV−1 cycles.
  - `SAMPLE` (1 cycle) stores the synced columns into `raw[4r+3:4r]`, then advances r (3 wraps to 0) and shifts `row`.
- **Frame done:** on the `SAMPLE` of row 3, `frame_done` pulses for one cycle and the `raw` snapshot is complete.
- **Debounce (per key, on `frame_done` only):**
  - If `raw[i] != key_press[i]`, `cnt[i]++`.
  - If `cnt[i]` would reach DEBOUNCE_SCANS, toggle `key_press[i]` and clear `cnt[i]`.
  - If `raw[i] == key_press[i]`, clear `cnt[i]`.
  - `cnt` width is `$clog2(DEBOUNCE_SCANS+1)`; counters saturate and never wrap.
- **Edge:** `key_edge[i]` is 1 for exactly the cycle in which `key_press[i]` first reads 1. It is registered together with `key_press`, so there is no extra latency.
- **Simultaneous keys:** any number of keys may assert `key_edge` in the same cycle. The block does no ghost filtering and no priority.
- **Bounce shorter than DEBOUNCE_SCANS frames:** produces no change and no edge.

## Timing
- **Reset values:** `row`=4'b1110, `key_press`=0, `key_edge`=0, all `cnt`=0, scan row 0, synchronizer flops 1 (released).
- **Async reset mid-scan:** returns immediately to the reset values. An in-progress debounce is discarded, and no edge is emitted on release.
- **Frame period:** 4*SCAN_DIV cycles.
- **Press latency:** from a stable closure to `key_press`/`key_edge`, at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 2 cycles, and at least DEBOUNCE_SCANS frames.
- **Release latency:** same bound.
- **Row settling:** the sample is taken SCAN_DIV−1 cycles after the row change, which leaves ≥ 2 cycles of synchronizer latency.
- **Key held across reset deassert:** reported as a fresh press after DEBOUNCE_SCANS frames, including its `key_edge`.

## Configuration
- `KEYPAD_RELEASE_EDGE_EN`:
  - **Defined:** adds output `key_release` (16 bits), a one-`clk` pulse in the cycle in which `key_press[i]` first reads 0 after being 1. Its reset value is 0.
  - **Undefined:** the port and its logic are absent, and releases produce no pulse.

## Structure
- **Package `keypad_pkg`:**
  - constants `KP_ROWS`=4, `KP_COLS`=4, `KP_KEYS`=16;
  - scan-state enum `{DRIVE, SAMPLE}`;
  - function `kp_index(row, col)` returning 4*row+col;
  - named key-index constants used by controllers (`KEY_START`=14, `KEY_OK`=10, `KEY_FAIL`=11, `KEY_NONE`=0).
- **Sub-module `key_debounce`:** one key, holding its counter, level and edge. Instantiated 16 times via generate, with `frame_done`, `raw[i]` and DEBOUNCE_SCANS as inputs.

## Test plan
All scenarios use SCAN_DIV=8 and DEBOUNCE_SCANS=3 (frame = 32 cycles).
1. **Reset:** assert `rst`=0 mid-scan → `row`=1110, `key_press`=0 and `key_edge`=0 asynchronously. After release, `row` cycles 1110→1101→1011→0111 every 8 cycles.
2. **Clean press:** close key (row 2, col 3) for 200 cycles → `key_press[11]`=1 within 3–4 frames, and `key_edge[11]` pulses exactly once for 1 cycle. Opening the key clears `key_press[11]` after 3–4 frames with no `key_edge`.
3. **Bounce:** toggle key 14 closed for 2 frames, open for 1 frame, closed for 2 frames, then open → `key_press[14]` stays 0 and `key_edge` stays 0.
4. **Simultaneous:** close keys 1 and 4 in the same cycle → `key_edge[1]` and `key_edge[4]` pulse in the same cycle.
5. **Reset mid-debounce:** close key 0, pull `rst` low after 2 frames, release `rst`, keep key 0 closed → one `key_edge[0]`, 3–4 frames after reset release.
6. **`KEYPAD_RELEASE_EDGE_EN` defined:** press then release key 10 → one `key_edge[10]` pulse, then one `key_release[10]` pulse 3–4 frames after opening.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad constants, scan-state enum and key-index helpers.
// Key index layout is 4*row + col; controllers use the named KEY_* indices.
package keypad_pkg;
    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = 16;

    localparam int KEY_START = 14;
    localparam int KEY_OK    = 10;
    localparam int KEY_FAIL  = 11;
    localparam int KEY_NONE  = 0;

    typedef enum logic {DRIVE, SAMPLE} scan_state_e;

    function automatic logic [3:0] kp_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin/consumer bundle. KEYPAD_RELEASE_EDGE_EN adds the key_release pulse bus.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KP_ROWS-1:0] row;
    logic [KP_COLS-1:0] col;
    logic [KP_KEYS-1:0] key_press;
    logic [KP_KEYS-1:0] key_edge;
`ifdef KEYPAD_RELEASE_EDGE_EN
    logic [KP_KEYS-1:0] key_release;

    modport master (output row, key_press, key_edge, key_release, input col);
    modport slave  (input row, key_press, key_edge, key_release, output col);
`else
    modport master (output row, key_press, key_edge, input col);
    modport slave  (input row, key_press, key_edge, output col);
`endif
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Single-key debouncer: level flips after DEBOUNCE_SCANS consecutive disagreeing frames.
// KEYPAD_RELEASE_EDGE_EN adds the release pulse output.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_done_i,
    input  logic raw_i,
`ifdef KEYPAD_RELEASE_EDGE_EN
    output logic release_o,
`endif
    output logic press_o,
    output logic edge_o
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          edge_q, edge_d;
    logic          rel_q, rel_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
            edge_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
            edge_q  <= edge_d;
            rel_q   <= rel_d;
        end
    end

    // The >= compare doubles as saturation: cnt never exceeds DEBOUNCE_SCANS-1.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = press_q;
        edge_d  = 1'b0;
        rel_d   = 1'b0;
        if (frame_done_i) begin
            if (raw_i != press_q) begin
                if (cnt_q >= CW'(DEBOUNCE_SCANS - 1)) begin
                    press_d = ~press_q;
                    cnt_d   = '0;
                    edge_d  = ~press_q;
                    rel_d   = press_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign press_o = press_q;
    assign edge_o  = edge_q;
`ifdef KEYPAD_RELEASE_EDGE_EN
    assign release_o = rel_q;
`endif
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, per-key debounce with edge pulses.
// KEYPAD_RELEASE_EDGE_EN enables the key_release pulse bus.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [KP_COLS-1:0] sync1_q, sync2_q;
    logic [KP_COLS-1:0] col_closed;
    scan_state_e        state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [1:0]         r_q, r_d;
    logic [KP_ROWS-1:0] row_q, row_d;
    logic [KP_KEYS-1:0] raw_q, raw_d;
    logic               frame_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= kp.col;
            sync2_q <= sync1_q;
        end
    end

    assign col_closed = ~sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DRIVE;
            div_q   <= '0;
            r_q     <= 2'd0;
            row_q   <= 4'b1110;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            r_q     <= r_d;
            row_q   <= row_d;
            raw_q   <= raw_d;
        end
    end

    // The debouncers consume raw_d so the row-3 columns land in the same frame_done cycle.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        r_d        = r_q;
        row_d      = row_q;
        raw_d      = raw_q;
        frame_done = 1'b0;
        case (state_q)
            DRIVE: begin
                if (div_q == DW'(SCAN_DIV - 2)) begin
                    state_d = SAMPLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SAMPLE: begin
                raw_d[kp_index(r_q, 2'd0) +: KP_COLS] = col_closed;
                r_d        = r_q + 2'd1;
                row_d      = {row_q[KP_ROWS-2:0], row_q[KP_ROWS-1]};
                frame_done = (r_q == 2'd3);
                state_d    = DRIVE;
            end
            default: state_d = DRIVE;
        endcase
    end

    assign kp.row = row_q;

    for (genvar i = 0; i < KP_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
            .clk          (clk),
            .rst          (rst),
            .frame_done_i (frame_done),
            .raw_i        (raw_d[i]),
`ifdef KEYPAD_RELEASE_EDGE_EN
            .release_o    (kp.key_release[i]),
`endif
            .press_o      (kp.key_press[i]),
            .edge_o       (kp.key_edge[i])
        );
    end
endmodule
